// File: rtl/cs_intra_sad_sched_pkg.sv
// Shared constants, state encoding and candidate substitution helper for the
// intra SAD scheduler.
package cs_intra_sad_sched_pkg;
  localparam int DATA_WIDTH     = 16;
  localparam int REG_BANK_DEPTH = 25;
  localparam int PACKET_LEN     = DATA_WIDTH * REG_BANK_DEPTH;
  localparam int PREDICTED_MODE = 2;
  localparam int MODE_W         = PREDICTED_MODE;
  localparam int BLK_COLS       = 8;
  localparam int BLK_ROWS       = 8;
  localparam int POS_W          = 8;
  localparam int TIMEOUT        = 64;
  localparam int WD_W           = $clog2(TIMEOUT);

  localparam logic [DATA_WIDTH-1:0] GREY0 = 16'h7F80;
  localparam logic [DATA_WIDTH-1:0] GREY  = 16'h3FC0;

  typedef enum logic [MODE_W-1:0] {
    MODE_LEFT = 2'd0,
    MODE_UP   = 2'd1,
    MODE_DC   = 2'd2,
    MODE_CP   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_WIN1 = 3'd2,
    ST_WIN2 = 3'd3,
    ST_OUT  = 3'd4
  } sched_state_e;

  function automatic logic [DATA_WIDTH-1:0] grey_sub(input logic unavail,
                                                     input logic [DATA_WIDTH-1:0] grey_val,
                                                     input logic [DATA_WIDTH-1:0] cand);
    return unavail ? grey_val : cand;
  endfunction
endpackage

// File: rtl/cs_blk_pos_cnt.sv
// Block position counter: col/row of the block being accepted, frame-start
// load, raster wrap and last-block flag.
module cs_blk_pos_cnt
  import cs_intra_sad_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             sof,
  output logic [POS_W-1:0] pos_col,
  output logic [POS_W-1:0] pos_row,
  output logic             pos_eof
);
  logic [POS_W-1:0] cnt_col;
  logic [POS_W-1:0] cnt_row;
  logic             last_col;

  // Position of the block presented now; a frame start overrides the counter.
  assign pos_col  = sof ? '0 : cnt_col;
  assign pos_row  = sof ? '0 : cnt_row;
  assign last_col = (pos_col == POS_W'(BLK_COLS - 1));
  assign pos_eof  = last_col && (pos_row == POS_W'(BLK_ROWS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_col <= '0;
      cnt_row <= '0;
    end else if (adv) begin
      if (last_col) begin
        cnt_col <= '0;
        cnt_row <= pos_eof ? '0 : pos_row + 1'b1;
      end else begin
        cnt_col <= pos_col + 1'b1;
        cnt_row <= pos_row;
      end
    end
  end
endmodule

// File: rtl/cs_intra_sad_sched.sv
// Sequences one block at a time through the free-running SAD engine: hold the
// block, align to a window, take mode then residual, hand the result downstream.
module cs_intra_sad_sched
  import cs_intra_sad_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sof,
  input  logic [PACKET_LEN-1:0] in_packet,
  input  logic [DATA_WIDTH-1:0] in_left0,
  input  logic [DATA_WIDTH-1:0] in_up0,
  input  logic [DATA_WIDTH-1:0] in_dc0,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic [DATA_WIDTH-1:0] in_up,
  input  logic [DATA_WIDTH-1:0] in_dc,
  output logic [PACKET_LEN-1:0] eng_y_in,
  output logic [DATA_WIDTH-1:0] eng_left0,
  output logic [DATA_WIDTH-1:0] eng_up0,
  output logic [DATA_WIDTH-1:0] eng_dc0,
  output logic [DATA_WIDTH-1:0] eng_left,
  output logic [DATA_WIDTH-1:0] eng_up,
  output logic [DATA_WIDTH-1:0] eng_dc,
  input  logic                  eng_busy,
  input  logic [PACKET_LEN-1:0] eng_resid,
  input  logic [MODE_W-1:0]     eng_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PACKET_LEN-1:0] out_resid,
  output logic [MODE_W-1:0]     out_mode,
  output logic [7:0]            out_col,
  output logic [7:0]            out_row,
  output logic                  out_eof,
  output logic                  err_timeout
);
  // state | meaning
  // IDLE  | ready for a block; accept loads holding regs and position
  // SYNC  | waiting for the first busy-low to align to a window boundary
  // WIN1  | engine deciding; busy-low captures the mode
  // WIN2  | engine producing residual; busy-low captures it
  // OUT   | result presented until downstream accepts
  sched_state_e state, state_nxt;

  logic             armed;
  logic             accept;
  logic             busy_low;
  logic             waiting;
  logic             wd_expired;
  logic [WD_W-1:0]  wd_cnt;
  logic [POS_W-1:0] pos_col;
  logic [POS_W-1:0] pos_row;
  logic             pos_eof;
  logic             no_left;
  logic             no_up;

  cs_blk_pos_cnt u_pos (
    .clk     (clk),
    .rst     (rst),
    .adv     (accept),
    .sof     (in_sof),
    .pos_col (pos_col),
    .pos_row (pos_row),
    .pos_eof (pos_eof)
  );

  assign no_left  = (pos_col == '0);
  assign no_up    = (pos_row == '0);
  assign busy_low = !eng_busy;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    waiting    = (state == ST_SYNC) || (state == ST_WIN1) || (state == ST_WIN2);
    wd_expired = waiting && eng_busy && (wd_cnt == '0);
    unique case (state)
      ST_IDLE: begin
        in_ready = armed;
        if (in_valid && armed) state_nxt = ST_SYNC;
      end
      ST_SYNC: if (wd_expired) state_nxt = ST_IDLE; else if (busy_low) state_nxt = ST_WIN1;
      ST_WIN1: if (wd_expired) state_nxt = ST_IDLE; else if (busy_low) state_nxt = ST_WIN2;
      ST_WIN2: if (wd_expired) state_nxt = ST_IDLE; else if (busy_low) state_nxt = ST_OUT;
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // armed keeps in_ready low for the first cycle out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  // Watchdog: down-counter reloaded on accept and on every engine busy-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (accept || (waiting && busy_low)) begin
      wd_cnt <= WD_W'(TIMEOUT - 1);
    end else if (waiting && (wd_cnt != '0)) begin
      wd_cnt <= wd_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_y_in    <= '0;
      eng_left0   <= '0;
      eng_up0     <= '0;
      eng_dc0     <= '0;
      eng_left    <= '0;
      eng_up      <= '0;
      eng_dc      <= '0;
      out_col     <= '0;
      out_row     <= '0;
      out_eof     <= 1'b0;
      out_mode    <= '0;
      out_resid   <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (accept) begin
        eng_y_in  <= in_packet;
        eng_left0 <= grey_sub(no_left, GREY0, in_left0);
        eng_left  <= grey_sub(no_left, GREY, in_left);
        eng_up0   <= grey_sub(no_up, GREY0, in_up0);
        eng_up    <= grey_sub(no_up, GREY, in_up);
        eng_dc0   <= grey_sub(no_left && no_up, GREY0, in_dc0);
        eng_dc    <= grey_sub(no_left && no_up, GREY, in_dc);
        out_col   <= pos_col;
        out_row   <= pos_row;
        out_eof   <= pos_eof;
      end
      // Residual belongs to the window after the one that produced the mode.
      if ((state == ST_WIN1) && busy_low) out_mode <= eng_mode;
      if ((state == ST_WIN2) && busy_low) out_resid <= eng_resid;
      if (wd_expired) err_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cs_intra_sad_sched.sv
// Self-checking bench for cs_intra_sad_sched with an engine model pulsing
// busy low every 6 cycles and per-window random mode/residual.
module tb_cs_intra_sad_sched;
  import cs_intra_sad_sched_pkg::*;

  localparam int NW = 2048;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_sof;
  logic [PACKET_LEN-1:0] in_packet;
  logic [DATA_WIDTH-1:0] in_left0, in_up0, in_dc0, in_left, in_up, in_dc;
  logic [PACKET_LEN-1:0] eng_y_in;
  logic [DATA_WIDTH-1:0] eng_left0, eng_up0, eng_dc0, eng_left, eng_up, eng_dc;
  logic                  eng_busy;
  logic [PACKET_LEN-1:0] eng_resid;
  logic [MODE_W-1:0]     eng_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [PACKET_LEN-1:0] out_resid;
  logic [MODE_W-1:0]     out_mode;
  logic [7:0]            out_col, out_row;
  logic                  out_eof;
  logic                  err_timeout;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   pos_n = 0;
  logic eng_en = 1'b1;
  logic [MODE_W-1:0] win_mode [NW];
  logic [15:0]       win_seed [NW];

  typedef struct {
    logic        sof;
    logic [95:0] cands;
    logic [95:0] exp_cands;
    int          col;
    int          row;
    int          hold;
  } vec_t;
  vec_t tbl [4];

  cs_intra_sad_sched dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_packet(in_packet), .in_left0(in_left0), .in_up0(in_up0), .in_dc0(in_dc0),
    .in_left(in_left), .in_up(in_up), .in_dc(in_dc), .eng_y_in(eng_y_in),
    .eng_left0(eng_left0), .eng_up0(eng_up0), .eng_dc0(eng_dc0), .eng_left(eng_left),
    .eng_up(eng_up), .eng_dc(eng_dc), .eng_busy(eng_busy), .eng_resid(eng_resid),
    .eng_mode(eng_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_resid(out_resid), .out_mode(out_mode), .out_col(out_col), .out_row(out_row),
    .out_eof(out_eof), .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [PACKET_LEN-1:0] resid_of(input int w);
    logic [PACKET_LEN-1:0] r;
    for (int i = 0; i < REG_BANK_DEPTH; i++)
      r[i*16 +: 16] = win_seed[w % NW] ^ 16'(i * 16'h1357);
    return r;
  endfunction

  function automatic logic [PACKET_LEN-1:0] rand_pkt();
    logic [PACKET_LEN-1:0] p;
    for (int i = 0; i < REG_BANK_DEPTH; i++) p[i*16 +: 16] = 16'($urandom);
    return p;
  endfunction

  // Neighbour availability from frame position: left missing in col 0, up in row 0.
  function automatic logic [95:0] model_cands(input int col, input int row, input logic [95:0] c);
    logic [15:0] l0, u0, d0, l, u, d;
    {l0, u0, d0, l, u, d} = c;
    if (col == 0) begin l0 = 16'h7F80; l = 16'h3FC0; end
    if (row == 0) begin u0 = 16'h7F80; u = 16'h3FC0; end
    if (col == 0 && row == 0) begin d0 = 16'h7F80; d = 16'h3FC0; end
    return {l0, u0, d0, l, u, d};
  endfunction

  // Engine model: values for the upcoming edge are set on the falling edge.
  initial begin
    eng_busy = 1'b1;
    eng_mode = '0;
    eng_resid = '0;
    forever begin
      @(negedge clk);
      eng_busy  = !(eng_en && (cyc % 6 == 5));
      eng_mode  = win_mode[(cyc / 6) % NW];
      eng_resid = resid_of(cyc / 6);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit: sim time exceeded, vectors=%0d", n_vec);
    $fatal(1, "bench stopped");
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_accept(input logic sof, input logic [95:0] cands,
                           input logic [PACKET_LEN-1:0] pkt, output int t);
    int n = 0;
    in_valid = 1'b1;
    in_sof = sof;
    in_packet = pkt;
    {in_left0, in_up0, in_dc0, in_left, in_up, in_dc} = cands;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 512'(in_ready), 512'(1));
    t = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic run_block(input logic sof, input logic [95:0] cands, input logic [95:0] exp_cands,
                           input int col, input int row, input logic eof, input int hold);
    logic [PACKET_LEN-1:0] pkt;
    logic [MODE_W-1:0]     exp_mode;
    logic [PACKET_LEN-1:0] exp_resid;
    int t, c1, c3, n;
    pkt = rand_pkt();
    do_accept(sof, cands, pkt, t);
    // Upstream keeps presenting a different block while busy; it must be ignored.
    in_valid = 1'b1;
    in_packet = ~pkt;
    {in_left0, in_up0, in_dc0, in_left, in_up, in_dc} = ~cands;
    check("busy_in_ready", 512'(in_ready), 512'(0));
    check("eng_cands", 512'({eng_left0, eng_up0, eng_dc0, eng_left, eng_up, eng_dc}), 512'(exp_cands));
    check("eng_y_in", 512'(eng_y_in), 512'(pkt));
    // Sync pulse is the first busy-low after the accept cycle; mode and residual follow.
    c1 = t + 1 + ((5 - ((t + 1) % 6) + 6) % 6);
    c3 = c1 + 12;
    exp_mode = win_mode[((c1 + 6) / 6) % NW];
    exp_resid = resid_of(c3 / 6);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("out_valid_seen", 512'(out_valid), 512'(1));
    check("latency", 512'(cyc - t), 512'(c3 + 1 - t));
    check("latency_max19", 512'((cyc - t) <= 19), 512'(1));
    check("eng_held", 512'({eng_left0, eng_up0, eng_dc0, eng_left, eng_up, eng_dc}), 512'(exp_cands));
    check("eng_y_held", 512'(eng_y_in), 512'(pkt));
    check("out_mode", 512'(out_mode), 512'(exp_mode));
    check("out_resid", 512'(out_resid), 512'(exp_resid));
    check("out_pos", 512'({out_col, out_row, out_eof}), 512'({8'(col), 8'(row), eof}));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_ctrl", 512'({out_valid, in_ready, out_mode, out_col, out_row, out_eof}),
            512'({1'b1, 1'b0, exp_mode, 8'(col), 8'(row), eof}));
      check("hold_resid", 512'(out_resid), 512'(exp_resid));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("after_handshake", 512'({out_valid, in_ready}), 512'(2'b01));
  endtask

  task automatic next_block(input logic sof, input int hold);
    logic [95:0] c;
    int p;
    c = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    p = sof ? 0 : pos_n;
    run_block(sof, c, model_cands(p % 8, p / 8, c), p % 8, p / 8, p == 63, hold);
    pos_n = (p + 1) % 64;
  endtask

  initial begin
    int t, gap;
    logic seen;
    for (int i = 0; i < NW; i++) begin
      win_mode[i] = 2'($urandom);
      win_seed[i] = 16'($urandom);
    end
    tbl[0] = '{1'b1, {6{16'h0100}}, {16'h7F80, 16'h7F80, 16'h7F80, 16'h3FC0, 16'h3FC0, 16'h3FC0}, 0, 0, 0};
    tbl[1] = '{1'b0, {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666},
               {16'h1111, 16'h7F80, 16'h3333, 16'h4444, 16'h3FC0, 16'h6666}, 1, 0, 10};
    tbl[2] = '{1'b1, {16'hABCD, 16'h1234, 16'h0000, 16'hFFFF, 16'h8001, 16'h7F80},
               {16'h7F80, 16'h7F80, 16'h7F80, 16'h3FC0, 16'h3FC0, 16'h3FC0}, 0, 0, 2};
    tbl[3] = '{1'b0, {16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006},
               {16'h0001, 16'h7F80, 16'h0003, 16'h0004, 16'h3FC0, 16'h0006}, 1, 0, 1};

    rst = 1'b1;
    in_valid = 1'b1;
    in_sof = 1'b0;
    in_packet = '1;
    {in_left0, in_up0, in_dc0, in_left, in_up, in_dc} = '1;
    out_ready = 1'b0;
    #2 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_ctrl", 512'({in_ready, out_valid, out_mode, out_col, out_row, out_eof, err_timeout,
            eng_left0, eng_up0, eng_dc0, eng_left, eng_up, eng_dc}), 512'(0));
      check("rst_wide", 512'({|eng_y_in, |out_resid}), 512'(0));
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1 check("rdy_after_release", 512'(in_ready), 512'(0));
    @(negedge clk);
    check("rdy_next_cycle", 512'(in_ready), 512'(1));

    for (int i = 0; i < 4; i++) begin
      run_block(tbl[i].sof, tbl[i].cands, tbl[i].exp_cands, tbl[i].col, tbl[i].row, 1'b0, tbl[i].hold);
      pos_n = ((tbl[i].sof ? 0 : pos_n) + 1) % 64;
    end

    // Full frame plus wrap into the next one.
    for (int i = 0; i < 70; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      next_block(i == 0, $urandom_range(0, 3));
    end

    // Engine stalls: watchdog drops the block.
    eng_en = 1'b0;
    repeat (2) @(negedge clk);
    do_accept(1'b0, 96'h0, rand_pkt(), t);
    pos_n = (pos_n + 1) % 64;
    seen = 1'b0;
    for (int n = 0; n < 100 && !err_timeout; n++) begin
      seen = seen | out_valid;
      @(negedge clk);
    end
    check("timeout_flag", 512'(err_timeout), 512'(1));
    check("timeout_cycles", 512'(cyc - t), 512'(65));
    check("timeout_no_out", 512'({seen, out_valid}), 512'(0));
    check("timeout_idle", 512'(in_ready), 512'(1));
    eng_en = 1'b1;
    repeat (2) @(negedge clk);
    next_block(1'b0, 0);
    check("err_sticky", 512'(err_timeout), 512'(1));

    // Asynchronous reset in the middle of a block.
    do_accept(1'b0, 96'h0123_4567_89AB_CDEF_0F0F_F0F0, rand_pkt(), t);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ctrl", 512'({in_ready, out_valid, out_mode, out_col, out_row, out_eof, err_timeout,
          eng_left0, eng_up0, eng_dc0, eng_left, eng_up, eng_dc}), 512'(0));
    check("midrst_wide", 512'({|eng_y_in, |out_resid}), 512'(0));
    @(negedge clk);
    rst = 1'b1;
    pos_n = 0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("midrst_no_out", 512'(seen), 512'(0));
    check("midrst_ready", 512'(in_ready), 512'(1));
    next_block(1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
